// File: rtl/sound_pkg.sv
// ---------------------------------------------------------------------------
// sound_pkg
//   Shared definitions for the audio mixing path: sample width and limits,
//   unity gain code, mixer FSM state encoding and the 16-bit saturation helper.
//   No ports.
// ---------------------------------------------------------------------------
package sound_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

  // Gain code that represents 1.0x; the mixer's right shift is derived from it.
  localparam int GAIN_UNITY = 8;

  // Width of the intermediate value handed to sat16(). Every caller
  // sign-extends its wider-than-16-bit result into this width first.
  localparam int WIDE_W = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } mix_state_e;

  // Clamp a wide signed value into the signed 16-bit sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [WIDE_W-1:0] v);
    if (v > WIDE_W'(SAMPLE_MAX)) begin
      return SAMPLE_MAX;
    end else if (v < WIDE_W'(SAMPLE_MIN)) begin
      return SAMPLE_MIN;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sound_dcblock.sv
// ---------------------------------------------------------------------------
// sound_dcblock
//   One-pole DC blocker placed after the mixer's saturation stage:
//     y = sat16(x - x_prev + y_prev - (y_prev >>> 8))
//   The output is combinational from the current input and the stored
//   state; x_prev / y_prev advance on every valid input so the caller can
//   register the result in the same cycle it captures out_valid.
//   Only present when SOUND_MIXER_DCBLOCK_EN is defined; otherwise this file
//   compiles to nothing.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high; clears filter history
//   in_valid    in   one-cycle strobe, in_sample is a new input
//   in_sample   in   signed 16-bit input sample
//   out_valid   out  mirrors in_valid
//   out_sample  out  signed 16-bit filtered sample (valid with out_valid)
// ---------------------------------------------------------------------------
`ifdef SOUND_MIXER_DCBLOCK_EN
module sound_dcblock
  import sound_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_sample
);

  logic signed [SAMPLE_W-1:0] x_prev_q;
  logic signed [SAMPLE_W-1:0] y_prev_q;
  logic signed [SAMPLE_W-1:0] y_prev_shr;
  logic signed [WIDE_W-1:0]   sum_w;

  // Leak term: the pole sits at 1 - 1/256.
  assign y_prev_shr = y_prev_q >>> 8;

  assign sum_w = WIDE_W'(in_sample) - WIDE_W'(x_prev_q)
               + WIDE_W'(y_prev_q)  - WIDE_W'(y_prev_shr);

  assign out_sample = sat16(sum_w);
  assign out_valid  = in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else if (in_valid) begin
      x_prev_q <= in_sample;
      y_prev_q <= out_sample;
    end
  end

endmodule
`endif

// File: rtl/sound_mixer.sv
// ---------------------------------------------------------------------------
// sound_mixer
//   Sums NUM_CH signed 16-bit channel samples weighted by unsigned per-channel
//   gains using a single multiply-accumulate shared across channels. A pass is
//   started by ce_sample: inputs are snapshotted, one channel is accumulated
//   per cycle, then the sum is scaled by >>> UNITY_SHIFT, saturated to 16 bit
//   and presented on mix_out with a one-cycle mix_valid pulse.
//   Latency from ce_sample to mix_valid is NUM_CH+2 cycles.
//
//   Optional feature, macro SOUND_MIXER_DCBLOCK_EN: a DC-blocking filter
//   (sound_dcblock) is inserted after saturation, adding one cycle of latency
//   (NUM_CH+3). Mute is then applied to the filter output while the filter
//   history keeps updating.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset (valid in any state)
//   ce_sample  in   one-cycle strobe starting a mix pass
//   ch_in      in   NUM_CH packed signed samples, ch k = [16k+15:16k]
//   ch_gain    in   NUM_CH packed unsigned gains, ch k = [GAIN_W*k +: GAIN_W]
//   mute       in   sampled in SAT; forces the next mix_out to 0
//   mix_out    out  signed mixed sample, held between updates
//   mix_valid  out  one-cycle pulse when mix_out updates
//   overrun    out  sticky: a strobe arrived while a pass was in progress
// ---------------------------------------------------------------------------
module sound_mixer
  import sound_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int GAIN_W      = 4,
  parameter int UNITY_SHIFT = $clog2(GAIN_UNITY)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce_sample,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_in,
  input  logic [NUM_CH*GAIN_W-1:0]     ch_gain,
  input  logic                         mute,
  output logic signed [SAMPLE_W-1:0]   mix_out,
  output logic                         mix_valid,
  output logic                         overrun
);

  // Accumulator is sized so the worst-case sum of NUM_CH full-scale products
  // cannot wrap.
  localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_CH) + 1;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int CNT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CH - 1);

  // Static checks on the configuration.
  initial begin : g_param_check
    assert (NUM_CH >= 1 && NUM_CH <= 8) else $error("sound_mixer: NUM_CH out of range");
    assert (ACC_W <= WIDE_W) else $error("sound_mixer: accumulator wider than sat16 input");
  end

  mix_state_e                    state_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic signed [ACC_W-1:0]       acc_d;
  logic [CNT_W-1:0]              ch_idx_q;
  logic [NUM_CH*SAMPLE_W-1:0]    samp_q;
  logic [NUM_CH*GAIN_W-1:0]      gain_q;
  logic signed [SAMPLE_W-1:0]    mix_out_q;
  logic                          mix_valid_q;
  logic                          overrun_q;

  logic [31:0]                   idx_w;
  logic signed [SAMPLE_W-1:0]    cur_s;
  logic [GAIN_W-1:0]             cur_g;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc_shr;
  logic signed [SAMPLE_W-1:0]    sat_val;

  // ---- ACC stage: select the current channel and multiply-accumulate ----
  assign idx_w = 32'(ch_idx_q);
  assign cur_s = samp_q[idx_w*SAMPLE_W +: SAMPLE_W];
  assign cur_g = gain_q[idx_w*GAIN_W +: GAIN_W];

  // Gain is unsigned: a zero MSB is prepended before the signed multiply.
  assign prod  = PROD_W'(cur_s) * PROD_W'($signed({1'b0, cur_g}));
  assign acc_d = acc_q + ACC_W'(prod);

  // ---- SAT stage: unity scaling and clamp to 16 bit ----
  assign acc_shr = acc_q >>> UNITY_SHIFT;
  assign sat_val = sat16(WIDE_W'(acc_shr));

`ifdef SOUND_MIXER_DCBLOCK_EN
  logic signed [SAMPLE_W-1:0] sat_q;
  logic                       sat_vld_q;
  logic                       mute_q;
  logic                       dc_vld;
  logic signed [SAMPLE_W-1:0] dc_y;

  sound_dcblock u_dcblock (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (sat_vld_q),
    .in_sample  (sat_q),
    .out_valid  (dc_vld),
    .out_sample (dc_y)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ch_idx_q    <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SOUND_MIXER_DCBLOCK_EN
      sat_q       <= '0;
      sat_vld_q   <= 1'b0;
      mute_q      <= 1'b0;
`endif
    end else begin
      mix_valid_q <= 1'b0;
`ifdef SOUND_MIXER_DCBLOCK_EN
      sat_vld_q   <= 1'b0;
`endif
      // A strobe outside IDLE is dropped; the running pass is not disturbed.
      if (ce_sample && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (ce_sample) begin
            samp_q   <= ch_in;
            gain_q   <= ch_gain;
            acc_q    <= '0;
            ch_idx_q <= '0;
            state_q  <= ACC;
          end
        end

        ACC: begin
          acc_q <= acc_d;
          if (ch_idx_q == LAST_IDX) begin
            state_q <= SAT;
          end else begin
            ch_idx_q <= ch_idx_q + CNT_W'(1);
          end
        end

        SAT: begin
`ifdef SOUND_MIXER_DCBLOCK_EN
          // Filter always sees the real sum; mute is held for the output.
          sat_q     <= sat_val;
          sat_vld_q <= 1'b1;
          mute_q    <= mute;
`else
          mix_out_q   <= mute ? '0 : sat_val;
          mix_valid_q <= 1'b1;
`endif
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase

`ifdef SOUND_MIXER_DCBLOCK_EN
      // ---- Filter output stage ----
      if (dc_vld) begin
        mix_out_q   <= mute_q ? '0 : dc_y;
        mix_valid_q <= 1'b1;
      end
`endif
    end
  end

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sound_mixer.sv
module tb_sound_mixer;

  localparam int NUM_CH      = 4;
  localparam int GAIN_W      = 4;
  localparam int UNITY_SHIFT = 3;
`ifdef SOUND_MIXER_DCBLOCK_EN
  localparam int LAT      = NUM_CH + 3;
  localparam bit DC_BUILD = 1'b1;
`else
  localparam int LAT      = NUM_CH + 2;
  localparam bit DC_BUILD = 1'b0;
`endif

  logic                       clk;
  logic                       reset;
  logic                       ce_sample;
  logic [NUM_CH*16-1:0]       ch_in;
  logic [NUM_CH*GAIN_W-1:0]   ch_gain;
  logic                       mute;
  logic signed [15:0]         mix_out;
  logic                       mix_valid;
  logic                       overrun;

  sound_mixer #(
    .NUM_CH      (NUM_CH),
    .GAIN_W      (GAIN_W),
    .UNITY_SHIFT (UNITY_SHIFT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce_sample (ce_sample),
    .ch_in     (ch_in),
    .ch_gain   (ch_gain),
    .mute      (mute),
    .mix_out   (mix_out),
    .mix_valid (mix_valid),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int val;
    int due;
  } exp_t;
  exp_t q[$];

  // Reference state: channel values as plain integers plus filter history.
  int cs[NUM_CH];
  int cg[NUM_CH];
  int xp = 0;
  int yp = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Weighted sum, divide by 8 rounding toward minus infinity, clamp,
  // optional DC blocker, then mute.
  function automatic int model(input bit m);
    longint sum;
    longint s;
    int     y;
    sum = 0;
    for (int k = 0; k < NUM_CH; k++) sum += longint'(cs[k]) * longint'(cg[k]);
    s = sum / 8;
    if ((sum % 8 != 0) && (sum < 0)) s = s - 1;
    y = clamp16(s);
    if (DC_BUILD) begin
      y  = clamp16(longint'(y) - xp + yp - ((yp - (((yp % 256) + 256) % 256)) / 256));
      xp = clamp16(s);
      yp = y;
    end
    return m ? 0 : y;
  endfunction

  // Scoreboard monitor: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && mix_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got mix_valid=1 mix_out=%0d at cycle %0d, expected no output",
                 mix_out, cyc);
      end else begin
        e = q.pop_front();
        check("mix_out", mix_out, e.val);
        check("latency_cycle", cyc, e.due);
      end
    end
  end

  task automatic set_all(input int s, input int g);
    for (int k = 0; k < NUM_CH; k++) begin
      cs[k] = s;
      cg[k] = g;
    end
  endtask

  task automatic strobe(input bit m);
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) begin
      ch_in[k*16 +: 16]         = 16'(cs[k]);
      ch_gain[k*GAIN_W +: GAIN_W] = GAIN_W'(cg[k]);
    end
    mute      = m;
    ce_sample = 1'b1;
    e.val = model(m);
    e.due = cyc + LAT;
    q.push_back(e);
    @(negedge clk);
    ce_sample = 1'b0;
  endtask

  task automatic wait_pass();
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    xp = 0;
    yp = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset     = 1'b1;
    ce_sample = 1'b0;
    ch_in     = '0;
    ch_gain   = '0;
    mute      = 1'b0;
    set_all(0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_mix_out", mix_out, 0);
    check("reset_mix_valid", {31'b0, mix_valid}, 0);
    check("reset_overrun", {31'b0, overrun}, 0);

    // Unity mix: 1000 - 200 = 800.
    set_all(0, 8);
    cs[0] = 1000;
    cs[1] = -200;
    strobe(1'b0);
    wait_pass();

    // Positive and negative saturation.
    reset_dut();
    set_all(32767, 15);
    strobe(1'b0);
    wait_pass();
    reset_dut();
    set_all(-32768, 15);
    strobe(1'b0);
    wait_pass();

    // Gain 4 on 4000 gives 2000; then muted.
    reset_dut();
    set_all(0, 0);
    cs[0] = 4000;
    cg[0] = 4;
    strobe(1'b0);
    wait_pass();
    strobe(1'b1);
    wait_pass();

    // Constant input on back-to-back strobes at minimum legal spacing.
    reset_dut();
    set_all(0, 8);
    cs[0] = 8000;
    for (int i = 0; i < 6; i++) begin
      strobe(1'b0);
      repeat (NUM_CH) @(negedge clk);
    end
    wait_pass();

    // Randomized passes; inputs are scrambled after each snapshot.
    for (int i = 0; i < 60; i++) begin
      int gap;
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 7) == 0) cs[k] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        else cs[k] = int'($urandom_range(0, 65535)) - 32768;
        cg[k] = int'($urandom_range(0, 15));
      end
      strobe($urandom_range(0, 3) == 0);
      gap = NUM_CH + int'($urandom_range(0, 3));
      repeat (gap) begin
        @(negedge clk);
        ch_in   = {$urandom, $urandom};
        ch_gain = 16'($urandom);
      end
    end
    wait_pass();
    check("no_overrun_at_legal_spacing", {31'b0, overrun}, 0);

    // Overrun: a second strobe two cycles into the pass is dropped.
    reset_dut();
    set_all(0, 8);
    cs[0] = 1200;
    cs[2] = 400;
    strobe(1'b0);
    @(negedge clk);
    ch_in     = {16'd5000, 16'd5000, 16'd5000, 16'd5000};
    ce_sample = 1'b1;
    @(negedge clk);
    ce_sample = 1'b0;
    wait_pass();
    check("overrun_set", {31'b0, overrun}, 1);
    check("overrun_output_consumed", q.size(), 0);
    repeat (LAT) @(negedge clk);
    check("overrun_sticky", {31'b0, overrun}, 1);

    // Reset during the second ACC cycle: no output, mix_out cleared.
    reset_dut();
    check("overrun_cleared_by_reset", {31'b0, overrun}, 0);
    set_all(0, 8);
    cs[0] = 1000;
    strobe(1'b0);
    wait_pass();
    check("pre_reset_mix_out", mix_out, 1000);
    cs[0] = 3000;
    strobe(1'b0);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    xp = 0;
    yp = 0;
    @(negedge clk);
    reset = 1'b0;
    check("midpass_reset_mix_out", mix_out, 0);
    check("midpass_reset_mix_valid", {31'b0, mix_valid}, 0);
    wait_pass();
    check("midpass_reset_mix_out_held", mix_out, 0);
    cs[0] = -2400;
    cs[3] = 800;
    strobe(1'b0);
    wait_pass();

    // Every expected output must have appeared within a bounded time.
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
